// File: rtl/pc.sv
// -----------------------------------------------------------------------------
// pc -- program counter of the single-cycle MIPS32 core.
//
// Holds the address of the instruction being fetched. On every rising clock
// edge (reset released) it advances to exactly one of:
//   - jump target  : {seq[31:28], jump_addr, 2'b00}   (highest priority)
//   - branch target: seq + (offset << 2)              (branch & zero)
//   - sequential   : seq = pc_value + 4
// All arithmetic wraps modulo 2^32 silently. There is no stall input: the PC
// updates every cycle.
//
// Parameters
//   RESET_ADDR  word-aligned address loaded while reset is asserted
//
// Ports
//   clk        in   1   system clock, rising-edge active
//   rst        in   1   asynchronous reset, active-low (0 = reset)
//   branch     in   1   current instruction is a conditional branch
//   zero       in   1   ALU zero flag; branch taken only when branch & zero
//   jump       in   1   current instruction is a J-type jump
//   jump_addr  in   26  instr[25:0], jump index in words
//   offset     in   32  sign-extended branch offset, in words
//   pc_value   out  32  current PC, registered
// -----------------------------------------------------------------------------
module pc #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic [31:0] offset,
  output logic [31:0] pc_value
);

  logic [31:0] seq;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  // The word-to-byte shift pushes offset[31:30] out of the 32-bit sum; they
  // are intentionally dropped.
  logic [1:0]  unused_offset_hi;
  assign unused_offset_hi = offset[31:30];

  // Both targets are relative to the already-incremented PC, matching the
  // MIPS delay-slot-free addressing used by this core.
  assign seq           = pc_value + 32'd4;
  assign branch_target = seq + {offset[29:0], 2'b00};
  assign jump_target   = {seq[31:28], jump_addr, 2'b00};

  // NOTE: next_pc gets a default before any branch of the if-chain, so every
  // path assigns it and no latch is inferred.
  always_comb begin
    next_pc = seq;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_value <= RESET_ADDR;
    end else begin
      pc_value <= next_pc;
    end
  end

endmodule

// File: tb/tb_pc.sv
// -----------------------------------------------------------------------------
// tb_pc -- self-checking bench for pc.
//
// A behavioural model computes each next PC from the architectural rules with
// plain 32-bit arithmetic (multiply by 4, mask the top nibble). Outputs are
// sampled 1 time unit after the rising edge; inputs are driven at that point
// so they are stable well before the next edge.
// -----------------------------------------------------------------------------
module tb_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [25:0] jump_addr;
  logic [31:0] offset;
  logic [31:0] pc_value;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_pc;

  pc #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .branch    (branch),
    .zero      (zero),
    .jump      (jump),
    .jump_addr (jump_addr),
    .offset    (offset),
    .pc_value  (pc_value)
  );

  always #5 clk = ~clk;

  // Reference model: next PC from the current PC and the control inputs.
  function automatic logic [31:0] model_next(input logic [31:0] cur,
                                             input logic j, input logic b,
                                             input logic z,
                                             input logic [25:0] ja,
                                             input logic [31:0] off);
    logic [31:0] s;
    logic [31:0] ja32;
    s    = cur + 32'd4;
    ja32 = {6'd0, ja};
    if (j)            return (s & 32'hF000_0000) + ja32 * 32'd4;
    else if (b && z)  return s + off * 32'd4;
    else              return s;
  endfunction

  // Apply one set of inputs across one rising edge and advance the model.
  task automatic clock_in(input logic j, input logic b, input logic z,
                          input logic [25:0] ja, input logic [31:0] off);
    jump = j; branch = b; zero = z; jump_addr = ja; offset = off;
    @(posedge clk);
    #1;
    exp_pc = model_next(exp_pc, j, b, z, ja, off);
  endtask

  task automatic test_reset;
    rst = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    jump_addr = '0; offset = '0;
    #2;
    exp_pc = 32'h0;
    total++;
    if (pc_value !== exp_pc)
      $display("FAIL reset_no_clock: pc_value=%h expected=%h", pc_value, exp_pc);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (pc_value !== exp_pc)
      $display("FAIL reset_hold: pc_value=%h expected=%h", pc_value, exp_pc);
    else passed++;
    rst = 1'b1;  // released mid-cycle; the next edge does the first update
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 4; i++) begin
      clock_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (pc_value !== exp_pc || pc_value !== 32'(i * 4))
        $display("FAIL seq_step%0d: pc_value=%h expected=%h", i, pc_value, 32'(i * 4));
      else passed++;
    end
  endtask

  task automatic test_jump;
    clock_in(1'b1, 1'b0, 1'b0, 26'd2, '0);
    total++;
    if (pc_value !== 32'd8)
      $display("FAIL jump_basic: pc_value=%h expected=%h", pc_value, 32'd8);
    else passed++;
  endtask

  task automatic test_branch;
    clock_in(1'b0, 1'b1, 1'b1, '0, -32'sd3);
    total++;
    if (pc_value !== 32'd0)
      $display("FAIL branch_taken_back: pc_value=%h expected=%h", pc_value, 32'd0);
    else passed++;
    clock_in(1'b0, 1'b1, 1'b0, '0, -32'sd3);
    total++;
    if (pc_value !== 32'd4)
      $display("FAIL branch_not_taken: pc_value=%h expected=%h", pc_value, 32'd4);
    else passed++;
  endtask

  task automatic test_jump_priority;
    // From 4, branch offset 0x0400_0002 lands on 8 + 0x1000_0008 = 0x1000_0010.
    clock_in(1'b0, 1'b1, 1'b1, '0, 32'h0400_0002);
    total++;
    if (pc_value !== 32'h1000_0010)
      $display("FAIL branch_far: pc_value=%h expected=%h", pc_value, 32'h1000_0010);
    else passed++;
    clock_in(1'b1, 1'b1, 1'b1, 26'h3, 32'h0000_0100);
    total++;
    if (pc_value !== 32'h1000_000C)
      $display("FAIL jump_priority: pc_value=%h expected=%h", pc_value, 32'h1000_000C);
    else passed++;
  endtask

  task automatic test_wrap;
    // From 0x1000_000C, jump to index 0 -> 0x1000_0000; then offset
    // discarding bits 31:30 (0xFBFF_FFFE -> -0x0400_0002 words) to 0xFFFF_FFFC.
    clock_in(1'b1, 1'b0, 1'b0, 26'h0, '0);
    clock_in(1'b0, 1'b1, 1'b1, '0, 32'hFBFF_FFFE);
    total++;
    if (pc_value !== 32'hFFFF_FFFC)
      $display("FAIL reach_top: pc_value=%h expected=%h", pc_value, 32'hFFFF_FFFC);
    else passed++;
    clock_in(1'b0, 1'b0, 1'b0, '0, '0);
    total++;
    if (pc_value !== 32'h0)
      $display("FAIL seq_wrap: pc_value=%h expected=%h", pc_value, 32'h0);
    else passed++;
  endtask

  task automatic test_async_reset;
    clock_in(1'b0, 1'b0, 1'b0, '0, '0);
    clock_in(1'b0, 1'b0, 1'b0, '0, '0);   // pc now 8
    jump = 1'b1; jump_addr = 26'h55;       // pending jump
    #2;
    rst = 1'b0;
    #1;
    exp_pc = 32'h0;
    total++;
    if (pc_value !== exp_pc)
      $display("FAIL async_reset: pc_value=%h expected=%h", pc_value, exp_pc);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (pc_value !== exp_pc)
      $display("FAIL reset_overrides_jump: pc_value=%h expected=%h", pc_value, exp_pc);
    else passed++;
    rst = 1'b1;
    clock_in(1'b1, 1'b0, 1'b0, 26'h55, '0);
    total++;
    if (pc_value !== 32'h0000_0154)
      $display("FAIL first_after_release: pc_value=%h expected=%h", pc_value, 32'h0000_0154);
    else passed++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      logic        j, b, z;
      logic [25:0] ja;
      logic [31:0] off;
      j   = ($urandom_range(0, 3) == 0);
      b   = $urandom_range(0, 1) == 1;
      z   = $urandom_range(0, 1) == 1;
      ja  = 26'($urandom);
      off = ($urandom_range(0, 1) == 1) ? 32'($signed(8'($urandom))) : $urandom;
      clock_in(j, b, z, ja, off);
      total++;
      if (pc_value !== exp_pc)
        $display("FAIL random_%0d: pc_value=%h expected=%h (j=%b b=%b z=%b)",
                 i, pc_value, exp_pc, j, b, z);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_jump;
    test_branch;
    test_jump_priority;
    test_wrap;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
